usb_in_arb: RTL and testbench

Round-robin arbiter that shares the single USB_CDC IN byte stream among several MCU-side byte sources, such as multiple FIFO interface instances or bridge channels. Each requester presents a valid/ready byte stream. The arbiter grants one requester at a time for a bounded burst and drives the CDC IN port through a one-entry output register. It sits between the requester-side interfaces and the USB_CDC IN FIFO port.

---
 rtl/usb_arb_pkg.sv | 17 +
 rtl/usb_rr_pick.sv | 30 +++
 rtl/usb_in_arb.sv | 118 +++++++++++
 tb/tb_usb_in_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_arb_pkg.sv
// Shared constants and types for the USB_CDC IN-stream round-robin arbiter.
package usb_arb_pkg;

  localparam int BYTE_W      = 8;
  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic bit num_req_legal(input int n);
    return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after 'last', wrapping.
module usb_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path infers a latch.
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    // Offset i = 1..NUM_REQ walks the ring starting just past the last grant.
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!any && (k == (int'(last) + i) % NUM_REQ) && eligible[k]) begin
          any     = 1'b1;
          pick[k] = 1'b1;
          idx     = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/usb_in_arb.sv
// Round-robin arbiter sharing the USB_CDC IN byte stream among NUM_REQ sources,
// with bounded bursts and a one-entry output register decoupled from arbitration.
module usb_in_arb
  import usb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_mask_i,
  output logic [BYTE_W-1:0]         in_data_o,
  output logic                      in_valid_o,
  input  logic                      in_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int              IDX_W     = $clog2(NUM_REQ);
  localparam int              CNT_W     = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

  if (!num_req_legal(NUM_REQ) || (BURST_MAX < 1)) begin : g_param_check
    $error("usb_in_arb: NUM_REQ must be 2..8 and BURST_MAX >= 1");
  end

  state_t              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BYTE_W-1:0]   data_q;
  logic                valid_q;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                g_valid;
  logic                g_mask;
  logic [BYTE_W-1:0]   g_data;
  logic                slot_free;
  logic                accept;
  logic                consume;
  logic                release_now;

  assign eligible = req_valid_i & req_mask_i;

  usb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .pick     (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // grant_q is all-zero in IDLE, so these reduce to "nothing granted" there.
  assign g_valid = |(req_valid_i & grant_q);
  assign g_mask  = |(req_mask_i & grant_q);

  always_comb begin
    g_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) g_data = req_data_i[BYTE_W*k +: BYTE_W];
    end
  end

  // A byte may enter when the register is empty or is being drained this cycle.
  assign slot_free   = ~valid_q | in_ready_i;
  assign req_ready_o = grant_q & req_mask_i & {NUM_REQ{slot_free}};
  assign accept      = |(req_ready_o & req_valid_i);
  assign consume     = valid_q & in_ready_i;
  assign release_now = (accept && (cnt_q == LAST_BEAT)) || !g_valid || !g_mask;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (pick_any) begin
        state_q <= GRANT;
        grant_q <= pick_onehot;
        last_q  <= pick_idx;
        cnt_q   <= '0;
      end
    end else begin
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
      if (release_now) begin
        state_q <= IDLE;
        grant_q <= '0;
      end
    end
  end

  // Output register lives independently of arbitration; a pending byte survives regrants.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= g_data;
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign in_data_o  = data_q;
  assign in_valid_o = valid_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q == GRANT) | valid_q;

endmodule

// File: tb/tb_usb_in_arb.sv
// Self-checking bench for usb_in_arb: directed scenarios plus randomized traffic
// compared every cycle against a queue/integer reference model.
module tb_usb_in_arb;

  localparam int NUM_REQ   = 4;
  localparam int BURST_MAX = 4;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   req_mask_i;
  logic [7:0]           in_data_o;
  logic                 in_valid_o;
  logic                 in_ready_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;

  usb_in_arb #(.NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_mask_i  (req_mask_i),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte sources: one queue per requester, front byte is what is offered.
  logic [7:0]         src_q [NUM_REQ][$];
  logic [7:0]         cons_q[$];
  logic [NUM_REQ-1:0] acc = '0;
  logic [NUM_REQ-1:0] en = '1;
  logic [NUM_REQ-1:0] nx_mask = '1;
  logic               nx_in_ready = 1'b1;

  // Reference model: granted index (-1 = none), bytes in this grant, last winner,
  // and the single output slot.
  int         m_cur, m_cnt, m_last;
  bit         m_full;
  logic [7:0] m_ob;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_cur = -1; m_cnt = 0; m_last = NUM_REQ - 1; m_full = 0; m_ob = 8'h00;
    end else begin
      bit took, drained;
      drained = m_full && in_ready_i;
      if (m_cur < 0) begin
        if (drained) m_full = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
          int j;
          j = (m_last + i) % NUM_REQ;
          if (m_cur < 0 && req_valid_i[j] && req_mask_i[j]) begin
            m_cur = j; m_last = j; m_cnt = 0;
          end
        end
      end else begin
        took = req_mask_i[m_cur] && (!m_full || in_ready_i) && req_valid_i[m_cur];
        if (took) begin
          m_ob = req_data_i[8*m_cur +: 8]; m_full = 1; m_cnt = m_cnt + 1;
        end else if (drained) begin
          m_full = 0;
        end
        if ((took && m_cnt == BURST_MAX) || !req_valid_i[m_cur] || !req_mask_i[m_cur]) m_cur = -1;
      end
    end
  end

  // Compare process: outputs are sampled mid-cycle, once inputs have settled.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      logic [NUM_REQ-1:0] e_grant, e_ready;
      e_grant = (m_cur < 0) ? '0 : (NUM_REQ'(1) << m_cur);
      e_ready = (m_cur >= 0 && req_mask_i[m_cur] && (!m_full || in_ready_i)) ? e_grant : '0;
      check("model_grant", grant_o, e_grant);
      check("model_ready", req_ready_o, e_ready);
      check("model_in_valid", in_valid_o, m_full);
      check("model_in_data", in_data_o, m_ob);
      check("model_busy", busy_o, (m_cur >= 0) || m_full);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NUM_REQ; k++)
      if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    in_ready_i = nx_in_ready;
    req_mask_i = nx_mask;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid_i[k]      = en[k] && (src_q[k].size() != 0);
      req_data_i[8*k +: 8] = (src_q[k].size() != 0) ? src_q[k][0] : 8'h00;
    end
    @(negedge clk_i);
    acc = req_valid_i & req_ready_o;
    if (in_valid_o && in_ready_i) cons_q.push_back(in_data_o);
  endtask

  function automatic bit sources_empty();
    for (int k = 0; k < NUM_REQ; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name);
    en = '1; nx_mask = '1; nx_in_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (sources_empty() && !in_valid_o && grant_o == '0) break;
      step();
    end
    check(name, {sources_empty(), in_valid_o, grant_o == '0}, 3'b101);
  endtask

  task automatic clear_sources();
    for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
    acc = '0;
  endtask

  task automatic do_reset();
    #2 rstn_i = 1'b0;
    clear_sources();
    step();
    #2 rstn_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; req_data_i = '0; req_valid_i = '0; req_mask_i = '1; in_ready_i = 1'b1;
    step();
    check("rst_grant", grant_o, 4'b0000);
    check("rst_ready", req_ready_o, 4'b0000);
    check("rst_in_valid", in_valid_o, 1'b0);
    check("rst_in_data", in_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    #2 rstn_i = 1'b1;

    // Single requester, three bytes back to back.
    src_q[1] = '{8'hA1, 8'hA2, 8'hA3};
    step(); check("single_t0_grant", grant_o, 4'b0000);
    step(); check("single_t1_grant", grant_o, 4'b0010);
            check("single_t1_ready", req_ready_o, 4'b0010);
    step(); check("single_t2_data", {in_valid_o, in_data_o}, {1'b1, 8'hA1});
    step(); check("single_t3_data", {in_valid_o, in_data_o}, {1'b1, 8'hA2});
    step(); check("single_t4_data", {in_valid_o, in_data_o}, {1'b1, 8'hA3});
            check("single_t4_grant", grant_o, 4'b0010);
    step(); check("single_t5_grant", grant_o, 4'b0000);
            check("single_t5_idle", {in_valid_o, busy_o}, 2'b00);
    drain("single_drain");

    // Backpressure: first byte must be held while the sink stalls.
    cons_q.delete();
    nx_in_ready = 1'b0;
    src_q[0] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    step(); check("bp_t0_grant", grant_o, 4'b0000);
    step(); check("bp_t1_grant", grant_o, 4'b0001);
            check("bp_t1_ready", req_ready_o, 4'b0001);
    for (int t = 2; t < 7; t++) begin
      step();
      check($sformatf("bp_t%0d_hold", t), {in_valid_o, in_data_o, req_ready_o}, {1'b1, 8'hB0, 4'b0000});
    end
    drain("bp_drain");
    check("bp_count", cons_q.size(), 4);
    for (int i = 0; i < 4 && i < cons_q.size(); i++)
      check($sformatf("bp_byte%0d", i), cons_q[i], 8'hB0 + i);

    // Mask the granted requester after its first byte.
    src_q[2] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    src_q[3] = '{8'hD0, 8'hD1};
    step(); check("mask_t0_grant", grant_o, 4'b0000);
    step(); check("mask_t1_grant", grant_o, 4'b0100);
    nx_mask = 4'b1011;
    step(); check("mask_t2_ready", req_ready_o, 4'b0000);
            check("mask_t2_out", {grant_o, in_valid_o, in_data_o}, {4'b0100, 1'b1, 8'hC0});
    step(); check("mask_t3_grant", grant_o, 4'b0000);
    step(); check("mask_t4_grant", grant_o, 4'b1000);
    begin
      int hits = 0;
      for (int t = 0; t < 8; t++) begin
        step();
        if (grant_o[2]) hits++;
      end
      check("mask_never_granted", hits, 0);
    end
    drain("mask_drain");

    // Asynchronous reset with a byte pending mid-burst.
    src_q[0] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
    step(); step(); step();
    check("rstmid_pending", {in_valid_o, grant_o}, {1'b1, 4'b0001});
    #2 rstn_i = 1'b0;
    #1;
    check("rstmid_cleared", {in_valid_o, grant_o, req_ready_o, busy_o}, 10'd0);
    clear_sources();
    step();
    #2 rstn_i = 1'b1;

    // Fairness: everyone always valid, full bursts, one idle cycle between grants.
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < 12; i++) src_q[k].push_back(8'(16*k + i));
    for (int t = 0; t < 22; t++) begin
      logic [3:0] exp_g;
      step();
      exp_g = (t % 5 == 0) ? 4'b0000 : (4'b0001 << (((t - 1) / 5) % 4));
      check($sformatf("fair_t%0d_grant", t), grant_o, exp_g);
    end
    clear_sources();
    drain("fair_drain");

    // Valid drop after one byte: requester 1 goes before requester 0 again.
    do_reset();
    src_q[0] = '{8'hF0};
    src_q[1] = '{8'h10, 8'h11};
    step(); check("vdrop_t0_grant", grant_o, 4'b0000);
    step(); check("vdrop_t1_grant", grant_o, 4'b0001);
    step(); check("vdrop_t2_grant", grant_o, 4'b0001);
    for (int i = 1; i <= 4; i++) src_q[0].push_back(8'hF0 + 8'(i));
    step(); check("vdrop_t3_grant", grant_o, 4'b0000);
    step(); check("vdrop_t4_grant", grant_o, 4'b0010);
    drain("vdrop_drain");

    // Randomized traffic, checked by the model on every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        en[k]      = ($urandom_range(0, 7) != 0);
        nx_mask[k] = ($urandom_range(0, 15) != 0);
        if (src_q[k].size() < 6 && $urandom_range(0, 2) == 0)
          src_q[k].push_back(8'($urandom_range(0, 255)));
      end
      nx_in_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
